// File: rtl/omega_egress_buffer_pkg.sv
// Shared constants and helpers for the omega egress buffer slice.
// Derived sizes are computed from the instance parameters through these functions.
package omega_egress_buffer_pkg;

  // Number of bits needed to represent value; log2(PORTS-1) gives the switch stage count.
  function automatic int log2(input int value);
    int bits;
    int v;
    bits = 0;
    v = value;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return bits;
  endfunction

  // Occupancy at which stall must rise so in-flight beats still fit.
  function automatic int stall_thresh(input int depth, input int latency);
    return depth - latency - 1;
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_PORTS = 8;
  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/egress_port_fifo.sv
// Single-port show-ahead FIFO with registered pointers/count and a sticky overflow flag.
// Head data reads as zero while empty so stale memory is never exposed.
module egress_port_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  nonempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !do_pop)
        overflow <= 1'b1;
    end
  end

  assign nonempty = !empty;
  assign dout     = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/omega_egress_buffer.sv
// Per-output-port egress buffering behind the registered omega network.
// Stall is decoded only from registered counts, so it has no path from this cycle's inputs.
module omega_egress_buffer
  import omega_egress_buffer_pkg::*;
#(
  parameter int WIDTH            = DEFAULT_WIDTH,
  parameter int PORTS            = DEFAULT_PORTS,
  parameter int DEPTH            = DEFAULT_DEPTH,
  parameter int LATENCY          = log2(PORTS - 1),
  parameter int ADDR_WIDTH_DEPTH = log2(DEPTH - 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:PORTS-1]       valid_in,
  input  logic [PORTS*WIDTH-1:0] d_in,
  output logic                   stall,
  input  logic [0:PORTS-1]       pop,
  output logic [0:PORTS-1]       q_valid,
  output logic [PORTS*WIDTH-1:0] q,
  output logic [0:PORTS-1]       overflow
);

  localparam int COUNT_WIDTH  = ADDR_WIDTH_DEPTH + 1;
  localparam int STALL_THRESH = stall_thresh(DEPTH, LATENCY);
  localparam logic [COUNT_WIDTH-1:0] THRESH_COUNT = COUNT_WIDTH'(STALL_THRESH);

  logic [COUNT_WIDTH-1:0] counts [PORTS];
  logic [PORTS-1:0]       near_full;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    egress_port_fifo #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (valid_in[p]),
      .din      (d_in[(p+1)*WIDTH-1 -: WIDTH]),
      .pop      (pop[p]),
      .dout     (q[(p+1)*WIDTH-1 -: WIDTH]),
      .nonempty (q_valid[p]),
      .count    (counts[p]),
      .overflow (overflow[p])
    );

    assign near_full[p] = (counts[p] >= THRESH_COUNT);
  end

  assign stall = |near_full;

endmodule
